// File: rtl/ahb_uart_pkg.sv
// Shared constants and types for the AHB-Lite transmit-only UART.
package ahb_uart_pkg;

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_BAUD   = 2'd2;

  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 8;
  localparam int ST_CNT_W   = 8;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} txState_e;

endpackage

// File: rtl/ahb_uart_fifo.sv
// Generic synchronous FIFO; a push on full is accepted only when a pop frees a slot in the same cycle.
module ahb_uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     drop_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, rdPtr_q;
  logic [AW:0]      count_q, count_d;
  logic             pushOk, popOk;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign pushOk  = push_i & (~full_o | pop_i);
  assign popOk   = pop_i & ~empty_o;
  assign drop_o  = push_i & ~pushOk;
  assign rdata_o = mem_q[rdPtr_q];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (pushOk && !popOk) count_d = count_q + 1'b1;
    else if (!pushOk && popOk) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (pushOk) wrPtr_q <= wrPtr_q + 1'b1;
      if (popOk) rdPtr_q <= rdPtr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (pushOk) mem_q[wrPtr_q] <= wdata_i;
  end

endmodule

// File: rtl/ahb_uart_tx.sv
// AHB-Lite slave with a TX FIFO draining into an 8N1 serialiser on TXD.
module ahb_uart_tx
  import ahb_uart_pkg::*;
#(
  parameter int          FIFO_DEPTH    = 16,
  parameter logic [15:0] BAUDDIV_RESET = 16'd868
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  output logic        TXD,
  output logic        TXINT
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic           valid_q, write_q;
  logic [1:0]     off_q;
  logic [15:0]    baud_q, baud_d, baudCnt_q, baudCnt_d, reload;
  logic           ovf_q, ovf_d;
  txState_e       state_q, state_d;
  logic [7:0]     shift_q, shift_d;
  logic [2:0]     bitIdx_q, bitIdx_d;
  logic           txd_q, txd_d;
  logic           dataWr, statusWr, baudWr;
  logic           fifoPop, fifoFull, fifoEmpty, fifoDrop;
  logic [7:0]     fifoData;
  logic [CW-1:0]  fifoCount;
  logic           unusedOk;

  assign unusedOk  = ^{HSIZE, HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:16]};
  assign dataWr    = valid_q & write_q & (off_q == OFF_DATA);
  assign statusWr  = valid_q & write_q & (off_q == OFF_STATUS);
  assign baudWr    = valid_q & write_q & (off_q == OFF_BAUD);
  assign reload    = baud_q - 16'd1;
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign TXD       = txd_q;
  assign TXINT     = fifoEmpty & (state_q == IDLE);

  ahb_uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (HCLK),
    .rstn_i  (HRESETn),
    .push_i  (dataWr),
    .pop_i   (fifoPop),
    .wdata_i (HWDATA[7:0]),
    .rdata_o (fifoData),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .drop_o  (fifoDrop),
    .count_o (fifoCount)
  );

  // A fresh overflow outranks a W1C in the same cycle.
  always_comb begin
    baud_d = baud_q;
    if (baudWr) baud_d = (HWDATA[15:0] == 16'd0) ? 16'd1 : HWDATA[15:0];
    ovf_d = ovf_q;
    if (statusWr && HWDATA[ST_OVF]) ovf_d = 1'b0;
    if (fifoDrop) ovf_d = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    baudCnt_d = baudCnt_q;
    bitIdx_d  = bitIdx_q;
    fifoPop   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifoEmpty) begin
          fifoPop   = 1'b1;
          shift_d   = fifoData;
          baudCnt_d = reload;
          state_d   = START;
        end
      end
      START: begin
        if (baudCnt_q == 16'd0) begin
          baudCnt_d = reload;
          bitIdx_d  = 3'd0;
          state_d   = DATA;
        end else begin
          baudCnt_d = baudCnt_q - 16'd1;
        end
      end
      DATA: begin
        if (baudCnt_q == 16'd0) begin
          baudCnt_d = reload;
          if (bitIdx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bitIdx_d = bitIdx_q + 3'd1;
            shift_d  = shift_q >> 1;
          end
        end else begin
          baudCnt_d = baudCnt_q - 16'd1;
        end
      end
      STOP: begin
        if (baudCnt_q == 16'd0) begin
          if (!fifoEmpty) begin
            fifoPop   = 1'b1;
            shift_d   = fifoData;
            baudCnt_d = reload;
            state_d   = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baudCnt_d = baudCnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // TXD is registered, so it follows the state being entered.
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_comb begin
    HRDATA = 32'd0;
    if (valid_q && !write_q) begin
      case (off_q)
        OFF_STATUS: begin
          HRDATA[ST_BUSY]  = (state_q != IDLE);
          HRDATA[ST_FULL]  = fifoFull;
          HRDATA[ST_EMPTY] = fifoEmpty;
          HRDATA[ST_OVF]   = ovf_q;
          HRDATA[ST_CNT_LSB +: ST_CNT_W] = 8'(fifoCount);
        end
        OFF_BAUD: HRDATA[15:0] = baud_q;
        default:  HRDATA = 32'd0;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      valid_q   <= 1'b0;
      write_q   <= 1'b0;
      off_q     <= 2'd0;
      baud_q    <= BAUDDIV_RESET;
      ovf_q     <= 1'b0;
      state_q   <= IDLE;
      shift_q   <= 8'd0;
      baudCnt_q <= 16'd0;
      bitIdx_q  <= 3'd0;
      txd_q     <= 1'b1;
    end else begin
      valid_q   <= HSEL & HREADY & HTRANS[1];
      write_q   <= HWRITE;
      off_q     <= HADDR[3:2];
      baud_q    <= baud_d;
      ovf_q     <= ovf_d;
      state_q   <= state_d;
      shift_q   <= shift_d;
      baudCnt_q <= baudCnt_d;
      bitIdx_q  <= bitIdx_d;
      txd_q     <= txd_d;
    end
  end

endmodule

// File: doc/ahb_uart_tx.md
Name: ahb_uart_tx

Overview:
AHB-Lite slave transmit-only UART for the Cortex-M0 DesignStart system. It replaces the ideal console model with a real serial output.
- It sits on the CPU AHB bus at the console address.
- CPU writes go into a TX FIFO.
- A baud-rate serialiser drains the FIFO onto TXD as 8N1 frames.
- Status and baud-divisor registers allow polled or interrupt-driven firmware.

Parameters:
FIFO_DEPTH, 16, TX FIFO entries; power of two, minimum 2.
BAUDDIV_RESET, 16'd868, reset value of the baud divisor (HCLK cycles per bit).

Ports:
HCLK  in  1  bus and core clock.
HRESETn  in  1  reset; synchronous, active-low, sampled on HCLK rising edge.
HSEL  in  1  slave select from the address decoder.
HADDR  in  32  byte address; only HADDR[3:2] is decoded.
HTRANS  in  2  transfer type; a transfer is valid when HTRANS[1]=1.
HWRITE  in  1  transfer is a write.
HSIZE  in  3  transfer size; ignored, all accesses treated as word.
HWDATA  in  32  write data, sampled in the data phase.
HREADY  in  1  bus ready; qualifies address-phase sampling.
HREADYOUT  out  1  constant 1 (zero wait state).
HRESP  out  1  constant 0 (OKAY).
HRDATA  out  32  read data, valid in the data phase.
TXD  out  1  serial output; idle high.
TXINT  out  1  level interrupt: FIFO empty AND serialiser idle.

Behaviour:
- Address phase:
  - On an HCLK edge with HSEL & HREADY & HTRANS[1], register valid=1, write=HWRITE and off=HADDR[3:2].
  - Otherwise register valid=0.
- Register map (offset : access : content):
  - 0x0 DATA : W : push HWDATA[7:0] into the FIFO. Reads return 0.
  - 0x4 STATUS : R/W1C :
    - bit0 busy (serialiser not IDLE)
    - bit1 full
    - bit2 empty
    - bit3 overflow (sticky; writing 1 clears it)
    - bits[15:8] FIFO count
    - all other bits 0
  - 0x8 BAUDDIV : R/W : HWDATA[15:0]. A write of 0 is stored as 1.
  - 0xC : unmapped. Reads return 0; writes are ignored.
- HRDATA is combinational from the registered offset and the current state. It is 0 when valid=0 or write=1.
- FIFO:
  - Synchronous, FIFO_DEPTH entries, count width clog2(FIFO_DEPTH)+1.
  - A push on full drops the byte and sets overflow, unless a pop occurs in the same cycle; then the push is accepted.
  - Pointers wrap modulo FIFO_DEPTH.
- Serialiser FSM, states IDLE, START, DATA, STOP:
  - IDLE: TXD=1. If the FIFO is non-empty, pop into shift reg, load baud_cnt=BAUDDIV-1, go to START.
  - START: TXD=0 for BAUDDIV cycles, then go to DATA with bit_idx=0.
  - DATA: TXD=shift[0], LSB first. Each bit lasts BAUDDIV cycles. After bit_idx=7, go to STOP.
  - STOP: TXD=1 for BAUDDIV cycles. On the final cycle:
    - if the FIFO is non-empty, pop and go straight to START (no idle gap);
    - else go to IDLE.
  - The baud counter counts down to 0; reaching 0 ends the bit and reloads BAUDDIV-1.
  - BAUDDIV is sampled at each reload. A write mid-frame takes effect from the next bit.
  - TXD is registered.
- Latency: for a DATA write whose data phase ends at edge N, with the FIFO empty and the FSM IDLE:
  - the byte is in the FIFO after edge N;
  - the FSM pops at edge N+1;
  - TXD falls after edge N+1;
  - the frame is exactly 10*BAUDDIV cycles.
- Reset (HRESETn=0 at an edge), including mid-frame:
  - FSM=IDLE, TXD=1, FIFO emptied, overflow=0, BAUDDIV=BAUDDIV_RESET;
  - valid=0, so HRDATA=0;
  - TXINT=1 from the following cycle.
- Simultaneous events:
  - Write of DATA while the FSM pops: both happen; count unchanged.
  - W1C on overflow in the same cycle as a new overflow: set wins.

Decomposition:
- Package ahb_uart_pkg holds:
  - offset constants OFF_DATA=2'd0, OFF_STATUS=2'd1, OFF_BAUD=2'd2;
  - STATUS bit-position constants;
  - FSM state enum (IDLE/START/DATA/STOP).
- Sub-module ahb_uart_fifo is a generic synchronous FIFO with push/pop/full/empty/count, parameterised on width and depth. The top level holds the AHB interface, registers and serialiser.

Test Plan:
1. Release reset, read STATUS and BAUDDIV -> STATUS=0x0000_0004, BAUDDIV=868, TXD=1, TXINT=1, HREADYOUT=1, HRESP=0.
2. Write BAUDDIV=4, then DATA=0x55 -> TXD falls one edge after the data phase. TXD sequence in 4-cycle bits is 0,1,0,1,0,1,0,1,0,1. Frame is 40 cycles, then TXINT=1.
3. Write BAUDDIV=100, then 18 back-to-back DATA writes 0x00..0x11:
   - first byte popped; the next 16 fill the FIFO; the 18th is dropped;
   - STATUS bit1=1, bit3=1, count=16;
   - writing STATUS=0x8 clears bit3 only.
4. Write BAUDDIV=2, then DATA 0xA5 and 0x3C consecutively -> second start bit follows the first stop bit with no idle cycle. Total 40 cycles, bits LSB first.
5. Drive HRESETn low for 1 cycle mid-data-bit with 3 bytes queued -> TXD=1 next edge, STATUS=0x4, no further frames emitted.
6. Read offset 0xC and write 0xC=0xFFFFFFFF; write BAUDDIV=0 -> 0xC reads 0, no state change; BAUDDIV reads 1.
